vga_capture: RTL and testbench

- Receive end of the VGA link: samples hsync, vsync and RGB332 on the 25 MHz pixel clock.
- Recovers line and frame timing and locks once the timing matches 640x480@60.
- Emits a per-pixel write stream (x, y, data) for a frame-buffer writer or a loopback checker of the on-board VGA generator.
- Sits between the external/looped-back VGA pins and video memory.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_capture_sync_edge.sv | 30 +++
 rtl/vga_capture.sv | 192 +++++++++++++++++++
 tb/tb_vga_capture.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, capture FSM states and the RGB332 pixel type,
// shared by the VGA generator and the capture side.
package vga_timing_pkg;

   localparam int VGA_H_SYNC      = 96;
   localparam int VGA_H_BACK      = 48;
   localparam int VGA_H_ACTIVE    = 640;
   localparam int VGA_H_FRONT     = 16;
   localparam int VGA_H_TOTAL     = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
   localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BACK;

   localparam int VGA_V_SYNC      = 2;
   localparam int VGA_V_BACK      = 33;
   localparam int VGA_V_ACTIVE    = 480;
   localparam int VGA_V_FRONT     = 10;
   localparam int VGA_V_TOTAL     = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;
   localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BACK;

   localparam int VGA_LOCK_FRAMES = 2;
   localparam int CNT_W           = 12;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } cap_state_e;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

endpackage

// File: rtl/vga_capture_sync_edge.sv
// Two-flop sync register with falling-edge detect; both stages reset to the
// inactive (high) level so leaving reset never produces a false edge.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic fall_o
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = pin_i;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign fall_o = !s1_q && s2_q;

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: recovers line/frame timing from hsync/vsync, locks onto
// the expected raster and emits a per-pixel (x, y, data) write stream.
//
//   state  | meaning
//   SEARCH | no frame boundary seen since reset
//   VERIFY | boundaries seen, counting consecutive good frames
//   LOCKED | timing matches; pixels are emitted
module vga_capture
   import vga_timing_pkg::*;
#(
   parameter int H_TOTAL     = VGA_H_TOTAL,
   parameter int V_TOTAL     = VGA_V_TOTAL,
   parameter int H_ACT_START = VGA_H_ACT_START,
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int V_ACT_START = VGA_V_ACT_START,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [2:0]  vga_r,
   input  logic [2:0]  vga_g,
   input  logic [1:0]  vga_b,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic [7:0]  pix_data,
   output logic        frame_start,
   output logic        locked,
   output logic        timing_err,
   output logic [11:0] line_len,
   output logic [11:0] frame_lines
);

   localparam int GC_W = $clog2(LOCK_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] H_LEN   = 12'(H_TOTAL);
   localparam logic [CNT_W-1:0] V_LEN   = 12'(V_TOTAL);
   localparam logic [CNT_W-1:0] H_LO    = 12'(H_ACT_START);
   localparam logic [CNT_W-1:0] H_HI    = 12'(H_ACT_START + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_LO    = 12'(V_ACT_START);
   localparam logic [CNT_W-1:0] V_HI    = 12'(V_ACT_START + V_ACTIVE);

   logic hfall, vfall;

   sync_edge u_hsync (.clk(clk), .rst(rst), .pin_i(hsync), .fall_o(hfall));
   sync_edge u_vsync (.clk(clk), .rst(rst), .pin_i(vsync), .fall_o(vfall));

   rgb332_t          rgb_s1_q, rgb_s1_d;
   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
   logic             v_pend_q, v_pend_d, line_bad_q, line_bad_d;
   logic             seen_hfall_q, seen_hfall_d;
   cap_state_e       state_q, state_d;
   logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
   logic             pix_valid_q, pix_valid_d;
   logic [9:0]       pix_x_q, pix_x_d;
   logic [8:0]       pix_y_q, pix_y_d;
   logic [7:0]       pix_data_q, pix_data_d;
   logic             frame_start_q, frame_start_d;
   logic             locked_q, locked_d;
   logic             timing_err_q, timing_err_d;

   logic             h_sat, boundary, line_bad_now, frame_good;
   logic [CNT_W-1:0] h_inc, v_inc;

   always_comb begin
      rgb_s1_d = '{r: vga_r, g: vga_g, b: vga_b};

      // h_d/v_d index the sample currently held in s1
      h_sat = (h_q == CNT_MAX);
      h_inc = h_sat ? h_q : h_q + 12'd1;
      v_inc = (v_q == CNT_MAX) ? v_q : v_q + 12'd1;
      h_d   = hfall ? '0 : h_inc;

      boundary = hfall && (v_pend_q || vfall);
      v_d      = v_q;
      if (hfall) begin
         v_d = boundary ? '0 : v_inc;
      end
      v_pend_d     = boundary ? 1'b0 : (v_pend_q || vfall);
      seen_hfall_d = seen_hfall_q || hfall;

      line_bad_now = line_bad_q
                     || (!hfall && h_sat)
                     || (hfall && seen_hfall_q && (h_inc != H_LEN));
      line_bad_d   = boundary ? 1'b0 : line_bad_now;

      line_len_d    = (hfall && seen_hfall_q) ? h_inc : line_len_q;
      frame_lines_d = boundary ? v_inc : frame_lines_q;
      frame_good    = (v_inc == V_LEN) && !line_bad_now && (state_q != SEARCH);

      state_d      = state_q;
      good_cnt_d   = good_cnt_q;
      timing_err_d = 1'b0;
      case (state_q)
         SEARCH: begin
            if (boundary) begin
               state_d    = VERIFY;
               good_cnt_d = '0;
            end
         end
         VERIFY: begin
            if (boundary) begin
               if (frame_good) begin
                  good_cnt_d = good_cnt_q + 1'b1;
                  if (good_cnt_q == GC_W'(LOCK_FRAMES - 1)) begin
                     state_d = LOCKED;
                  end
               end else begin
                  good_cnt_d   = '0;
                  timing_err_d = 1'b1;
               end
            end
         end
         LOCKED: begin
            // a bad line drops lock at once; a boundary in the same cycle is one bad frame
            if (boundary ? !frame_good : line_bad_now) begin
               state_d      = VERIFY;
               good_cnt_d   = '0;
               timing_err_d = 1'b1;
            end
         end
         default: begin
            state_d    = SEARCH;
            good_cnt_d = '0;
         end
      endcase

      frame_start_d = boundary;
      locked_d      = (state_d == LOCKED);

      pix_valid_d = locked_q && (h_d >= H_LO) && (h_d < H_HI)
                    && (v_d >= V_LO) && (v_d < V_HI);
      pix_x_d     = pix_valid_d ? 10'(h_d - H_LO) : pix_x_q;
      pix_y_d     = pix_valid_d ? 9'(v_d - V_LO) : pix_y_q;
      pix_data_d  = pix_valid_d ? rgb_s1_q : pix_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_s1_q      <= '0;
         h_q           <= '0;
         v_q           <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         v_pend_q      <= 1'b0;
         line_bad_q    <= 1'b0;
         seen_hfall_q  <= 1'b0;
         state_q       <= SEARCH;
         good_cnt_q    <= '0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_data_q    <= '0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         timing_err_q  <= 1'b0;
      end else begin
         rgb_s1_q      <= rgb_s1_d;
         h_q           <= h_d;
         v_q           <= v_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         v_pend_q      <= v_pend_d;
         line_bad_q    <= line_bad_d;
         seen_hfall_q  <= seen_hfall_d;
         state_q       <= state_d;
         good_cnt_q    <= good_cnt_d;
         pix_valid_q   <= pix_valid_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_data_q    <= pix_data_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         timing_err_q  <= timing_err_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_data    = pix_data_q;
   assign frame_start = frame_start_q;
   assign locked      = locked_q;
   assign timing_err  = timing_err_q;
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a shrunken raster (32 clk x 16 lines)
// so that many frames fit in a short run.
module tb_vga_capture;
   import vga_timing_pkg::*;

   localparam int HT = 32, HS = 4, HAS = 8, HA = 16;
   localparam int VT = 16, VS = 2, VAS = 3, VA = 10;

   logic        clk = 1'b0;
   logic        rst, hsync, vsync;
   logic [2:0]  vga_r, vga_g;
   logic [1:0]  vga_b;
   logic        pix_valid, frame_start, locked, timing_err;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [7:0]  pix_data;
   logic [11:0] line_len, frame_lines;

   always #20 clk = ~clk;

   vga_capture #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACTIVE(HA),
      .V_ACT_START(VAS), .V_ACTIVE(VA), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
      .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
      .line_len(line_len), .frame_lines(frame_lines)
   );

   int n_checks = 0, n_errors = 0;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // output monitor, sampled 1 time unit after each rising edge
   int cyc = 0, pv_cnt = 0, pv_bad = 0, err_cnt = 0, err_cyc = 0;
   int fs_cnt = 0, fs_cyc = 0, rise_cnt = 0, rise_on_fs = 0;
   int first_x = -1, first_y = -1, first_d = -1, last_x = -1, last_y = -1, last_d = -1;
   logic locked_prev = 1'b0;

   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (pix_valid) begin
         if (pv_cnt == 0) begin
            first_x = int'(pix_x); first_y = int'(pix_y); first_d = int'(pix_data);
         end
         last_x = int'(pix_x); last_y = int'(pix_y); last_d = int'(pix_data);
         if (pix_data !== 8'(pix_x + 10'(pix_y))) pv_bad++;
         pv_cnt++;
      end
      if (timing_err) begin err_cnt++; err_cyc = cyc; end
      if (frame_start) begin fs_cnt++; fs_cyc = cyc; end
      if (locked && !locked_prev) begin rise_cnt++; rise_on_fs = int'(frame_start); end
      locked_prev = locked;
   end

   int line_cyc = 0;

   task automatic put(input int v, input int h);
      logic [7:0] d;
      d = 8'd0;
      if (h >= HAS && h < HAS + HA && v >= VAS && v < VAS + VA) d = 8'(h - HAS + v - VAS);
      hsync = (h >= HS);
      vsync = (v >= VS);
      {vga_r, vga_g, vga_b} = d;
      @(negedge clk);
   endtask

   task automatic drive_seg(input int v, input int h0, input int h1);
      if (h0 == 0) line_cyc = cyc;
      for (int h = h0; h <= h1; h++) put(v, h);
   endtask

   task automatic drive_lines(input int v0, input int v1);
      for (int v = v0; v <= v1; v++) drive_seg(v, 0, HT - 1);
   endtask

   int e0, p0, r0;

   initial begin
      rst = 1'b1; hsync = 1'b1; vsync = 1'b1;
      vga_r = '0; vga_g = '0; vga_b = '0;
      repeat (3) @(negedge clk);
      check_val("rst_locked", locked, 0);
      check_val("rst_pix_valid", pix_valid, 0);
      check_val("rst_state", int'(dut.state_q), int'(SEARCH));
      rst = 1'b0;

      // nominal raster: lock on the third boundary
      drive_lines(0, VT - 1);
      check_val("b1_state", int'(dut.state_q), int'(VERIFY));
      check_val("b1_good_cnt", dut.good_cnt_q, 0);
      check_val("b1_fs_cnt", fs_cnt, 1);
      drive_lines(0, VT - 1);
      check_val("b2_state", int'(dut.state_q), int'(VERIFY));
      check_val("b2_good_cnt", dut.good_cnt_q, 1);
      check_val("b2_locked", locked, 0);
      drive_lines(0, VT - 1);
      check_val("b3_state", int'(dut.state_q), int'(LOCKED));
      check_val("b3_rise_cnt", rise_cnt, 1);
      check_val("b3_rise_on_fs", rise_on_fs, 1);
      check_val("pix_count", pv_cnt, HA * VA);
      check_val("first_x", first_x, 0);
      check_val("first_y", first_y, 0);
      check_val("first_data", first_d, 0);
      check_val("last_x", last_x, HA - 1);
      check_val("last_y", last_y, VA - 1);
      check_val("last_data", last_d, 8'h18);
      check_val("pix_data_errs", pv_bad, 0);
      check_val("line_len_nom", line_len, HT);
      check_val("frame_lines_nom", frame_lines, VT);
      check_val("no_err_nominal", err_cnt, 0);

      // one short line while locked
      e0 = err_cnt;
      drive_seg(0, 0, HT - 1);
      check_val("fs_latency", fs_cyc - line_cyc, 2);
      drive_lines(1, 4);
      drive_seg(5, 0, HT - 2);
      drive_seg(6, 0, HT - 1);
      check_val("short_line_len", line_len, HT - 1);
      check_val("short_err_cnt", err_cnt - e0, 1);
      check_val("short_err_latency", err_cyc - line_cyc, 2);
      check_val("short_locked", locked, 0);
      check_val("short_state", int'(dut.state_q), int'(VERIFY));
      drive_lines(7, VT - 1);
      drive_lines(0, VT - 1);
      check_val("short_frame_err", err_cnt - e0, 2);
      drive_lines(0, VT - 1);
      check_val("short_pre_relock", locked, 0);
      drive_lines(0, VT - 1);
      check_val("short_relock", locked, 1);

      // frame one line short
      e0 = err_cnt;
      drive_lines(0, VT - 2);
      drive_seg(0, 0, HT - 1);
      check_val("short_frame_lines", frame_lines, VT - 1);
      check_val("short_frame_locked", locked, 0);
      check_val("short_frame_err_cnt", err_cnt - e0, 1);
      drive_lines(1, VT - 1);
      drive_lines(0, VT - 1);
      drive_lines(0, VT - 1);
      check_val("relock_2", locked, 1);

      // hsync stuck high: h saturates, lock drops once
      drive_lines(0, 4);
      drive_seg(5, 0, HT - 1);
      e0 = err_cnt;
      p0 = pv_cnt;
      drive_seg(5, HT, HT + 4999);
      check_val("sat_h", dut.h_q, 4095);
      check_val("sat_no_pix", pv_cnt - p0, 0);
      check_val("sat_err_cnt", err_cnt - e0, 1);
      check_val("sat_locked", locked, 0);
      drive_lines(6, VT - 1);
      drive_lines(0, VT - 1);
      drive_lines(0, VT - 1);

      // reset pulse mid-frame while locked
      drive_lines(0, 4);
      drive_seg(5, 0, 15);
      check_val("pre_rst_locked", locked, 1);
      rst = 1'b1;
      put(5, 16);
      rst = 1'b0;
      check_val("mid_rst_pix_valid", pix_valid, 0);
      check_val("mid_rst_pix_x", pix_x, 0);
      check_val("mid_rst_pix_y", pix_y, 0);
      check_val("mid_rst_pix_data", pix_data, 0);
      check_val("mid_rst_frame_start", frame_start, 0);
      check_val("mid_rst_locked", locked, 0);
      check_val("mid_rst_timing_err", timing_err, 0);
      check_val("mid_rst_line_len", line_len, 0);
      check_val("mid_rst_frame_lines", frame_lines, 0);
      check_val("mid_rst_state", int'(dut.state_q), int'(SEARCH));
      r0 = rise_cnt;
      drive_seg(5, 17, HT - 1);
      drive_lines(6, VT - 1);
      drive_lines(0, VT - 1);
      drive_lines(0, VT - 1);
      check_val("rst_b2_locked", locked, 0);
      drive_seg(0, 0, HT - 1);
      check_val("rst_b3_locked", locked, 1);
      check_val("rst_rise_cnt", rise_cnt - r0, 1);
      check_val("rst_rise_on_fs", rise_on_fs, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
